dmem_responder: RTL and testbench

- Multicycle data-memory responder: the target end of the datapath's load/store port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then performs byte, half or word access with RISC-V funct3 semantics.
- Returns a one-cycle response pulse carrying load data or an error flag; the datapath stalls its PC until the response arrives.

---
 rtl/dmem_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Target end of the datapath load/store port. Takes one request at a time
// over a valid/ready handshake, waits a programmable number of cycles, then
// performs a byte/half/word access with RISC-V funct3 semantics and returns
// a single-cycle response pulse.
//
// Ports:
//   rclk        clock, rising edge
//   rst         asynchronous active-high reset (clears memory too)
//   req_valid   request present
//   req_ready   responder is idle and will accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  access size/sign (B/H/W/BU/HU)
//   req_addr    byte address
//   req_wdata   right-aligned store data
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   extended load data; 0 for stores and errors; held between pulses
//   rsp_err     misaligned, out-of-range or illegal funct3; held between pulses
//
// state  | meaning
// IDLE   | ready for a request, captures it on req_valid
// WAIT   | wait states, counter counts down to 0
// ACCESS | error check, memory write or load lane select
// RESP   | rsp_valid pulse

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_INIT   = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
    localparam logic [31:0]   ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_we;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic          w_f3_legal;
    logic          w_misalign;
    logic          w_out_of_range;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_store_word;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (LATENCY > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------- request capture
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= CNT_INIT;
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------- error check
    always_comb begin
        w_f3_legal = 1'b0;
        case (r_funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = ~r_we;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word.
    assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_out_of_range = (r_addr >= ADDR_LIMIT);
    assign w_err          = ~w_f3_legal | w_misalign | w_out_of_range;

    // ------------------------------------------------------- data path
    assign w_idx  = r_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_load_data = 32'h0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'h0, w_half};
            3'b010:  w_load_data = w_word;
            default: w_load_data = 32'h0;
        endcase
    end

    // Read-modify-write of the addressed word; untouched lanes keep their data.
    always_comb begin
        w_store_word = w_word;
        case (r_funct3[1:0])
            2'b00: begin
                case (r_addr[1:0])
                    2'b00:   w_store_word[7:0]   = r_wdata[7:0];
                    2'b01:   w_store_word[15:8]  = r_wdata[7:0];
                    2'b10:   w_store_word[23:16] = r_wdata[7:0];
                    default: w_store_word[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) begin
                    w_store_word[31:16] = r_wdata[15:0];
                end else begin
                    w_store_word[15:0] = r_wdata[15:0];
                end
            end
            2'b10:   w_store_word = r_wdata;
            default: w_store_word = w_word;
        endcase
    end

    // ------------------------------------------------------- storage
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == S_ACCESS && r_we && !w_err) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    // ------------------------------------------------------- response
    // Loaded on the ACCESS edge so the values are stable for the whole RESP
    // cycle and then hold until the next response.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load_data;
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_valid, a_ready, a_we, a_rsp_valid, a_err;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_rdata;

    logic        b_valid, b_ready, b_we, b_rsp_valid, b_err;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata, b_rdata;

    dmem_responder #(.DEPTH(64), .LATENCY(LAT_A)) u_dut (
        .rclk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(LAT_B)) u_dut0 (
        .rclk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;     // number of rising edges so far
    int pops_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          due;   // edge after which rsp_valid must be seen high
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ma, mb;

    // Scoreboard pop for instance A (LATENCY=2)
    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_rsp: rsp_valid=1 after edge %0d, none outstanding", cyc);
            end else begin
                ma = q_a.pop_front();
                total += 3;
                if (cyc !== ma.due) begin
                    bad++;
                    $display("FAIL %s_latency: rsp after edge %0d, required edge %0d", ma.name, cyc, ma.due);
                end
                if (a_err !== ma.err) begin
                    bad++;
                    $display("FAIL %s_err: got %0b, required %0b", ma.name, a_err, ma.err);
                end
                if (a_rdata !== ma.rd) begin
                    bad++;
                    $display("FAIL %s_rdata: got %08h, required %08h", ma.name, a_rdata, ma.rd);
                end
            end
        end
    end

    // Scoreboard pop for instance B (LATENCY=0)
    always @(negedge clk) begin
        if (b_rsp_valid) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_rsp: rsp_valid=1 after edge %0d, none outstanding", cyc);
            end else begin
                mb = q_b.pop_front();
                pops_b++;
                total += 3;
                if (cyc !== mb.due) begin
                    bad++;
                    $display("FAIL %s_latency: rsp after edge %0d, required edge %0d", mb.name, cyc, mb.due);
                end
                if (b_err !== mb.err) begin
                    bad++;
                    $display("FAIL %s_err: got %0b, required %0b", mb.name, b_err, mb.err);
                end
                if (b_rdata !== mb.rd) begin
                    bad++;
                    $display("FAIL %s_rdata: got %08h, required %08h", mb.name, b_rdata, mb.rd);
                end
            end
        end
    end

    task automatic wait_a(input string name);
        int t;
        t = 0;
        while (q_a.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (q_a.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, q_a.size());
            q_a.delete();
        end
    endtask

    // One request on instance A; the expected response goes to the scoreboard.
    task automatic send_a(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                          input string name);
        int t;
        exp_t e;
        @(negedge clk);
        a_valid = 1'b1; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wd;
        t = 0;
        while (!a_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (!a_ready) begin
            bad++;
            $display("FAIL %s_accept: req_ready=%0b, required 1", name, a_ready);
            a_valid = 1'b0;
        end else begin
            e.err = eerr; e.rd = erd; e.name = name;
            e.due = cyc + 1 + LAT_A + 1;   // accepted on edge cyc+1
            q_a.push_back(e);
            @(negedge clk);
            a_valid = 1'b0;
            wait_a(name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_f3 = 3'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_f3 = 3'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        total += 5;
        if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b, required 1", a_ready); end
        if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0b, required 0", a_rsp_valid); end
        if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %08h, required 00000000", a_rdata); end
        if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b, required 0", a_err); end
        if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_b: got %0b, required 1", b_ready); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        send_a(1'b1, 3'b010, 32'h0, 32'h1111_1111, 1'b0, 32'h0, "prep_sw0");
        send_a(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h1111_1111, "prep_lw0");
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_f3 = 3'b010; a_addr = 32'h0; a_wdata = 32'hCAFE_F00D;
        @(negedge clk);   // accepted; now in WAIT
        a_valid = 1'b0;
        total++;
        if (a_ready !== 1'b0) begin bad++; $display("FAIL midwait_ready_wait: got %0b, required 0", a_ready); end
        #1 rst = 1'b1;
        #1;
        total++;
        if (a_ready !== 1'b1) begin bad++; $display("FAIL midwait_ready_in_reset: got %0b, required 1", a_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (a_rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL midwait_no_rsp: rsp_valid=%0b at sample %0d, required 0", a_rsp_valid, i);
            end
        end
        send_a(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0, "lw0_after_reset");
    endtask

    task automatic test_word();
        send_a(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, "sw10");
        send_a(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "lw10");
        @(negedge clk);
        total++;
        if (a_rdata !== 32'hDEAD_BEEF || a_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_hold: rdata=%08h valid=%0b, required deadbeef/0", a_rdata, a_rsp_valid);
        end
    endtask

    task automatic test_subword_loads();
        send_a(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, "lb13");
        send_a(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, "lbu13");
        send_a(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFF_BEEF, "lh10");
        send_a(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_DEAD, "lhu12");
        send_a(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFEF, "lb10");
    endtask

    task automatic test_store_lanes();
        send_a(1'b1, 3'b000, 32'h11, 32'h0000_00AA, 1'b0, 32'h0, "sb11");
        send_a(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_AAEF, "lw10_after_sb");
        send_a(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAA, "lb11");
        send_a(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000_AAEF, "lhu10");
        send_a(1'b1, 3'b001, 32'h12, 32'hFFFF_1234, 1'b0, 32'h0, "sh12");
        send_a(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234_AAEF, "lw10_after_sh");
    endtask

    task automatic test_errors();
        send_a(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, "err_lw12");
        send_a(1'b0, 3'b001, 32'h01, 32'h0, 1'b1, 32'h0, "err_lh01");
        send_a(1'b1, 3'b010, 32'h100, 32'h5555_5555, 1'b1, 32'h0, "err_sw100");
        send_a(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, "err_ld_f3_011");
        send_a(1'b1, 3'b001, 32'h13, 32'h0000_FFFF, 1'b1, 32'h0, "err_sh13");
        send_a(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 1'b1, 32'h0, "err_st_f3_100");
        send_a(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234_AAEF, "lw10_unchanged");
    endtask

    task automatic test_boundary();
        send_a(1'b0, 3'b010, 32'hFC, 32'h0, 1'b0, 32'h0, "lw_fc");
        send_a(1'b1, 3'b000, 32'hFF, 32'h0000_0080, 1'b0, 32'h0, "sb_ff");
        send_a(1'b0, 3'b000, 32'hFF, 32'h0, 1'b0, 32'hFFFF_FF80, "lb_ff");
        send_a(1'b0, 3'b010, 32'hFC, 32'h0, 1'b0, 32'h8000_0000, "lw_fc_after_sb");
        send_a(1'b0, 3'b100, 32'h100, 32'h0, 1'b1, 32'h0, "err_lbu_100");
        send_a(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, "err_lw_top");
    endtask

    // LATENCY=0 instance with req_valid held: IDLE, ACCESS, RESP repeat, so
    // acceptances are 3 edges apart and ready is low on the 2 samples between.
    task automatic test_back_to_back();
        int acc[$];
        int low_cnt;
        int t;
        exp_t e;
        low_cnt = 0;
        pops_b = 0;
        @(negedge clk);
        b_valid = 1'b1; b_we = 1'b0; b_f3 = 3'b010; b_addr = 32'h8; b_wdata = 32'h0;
        for (int i = 0; i < 13; i++) begin
            if (b_ready) begin
                e.err = 1'b0; e.rd = 32'h0; e.name = "b2b_lw8";
                e.due = cyc + 1 + LAT_B + 1;
                q_b.push_back(e);
                acc.push_back(cyc + 1);
                if (acc.size() > 1) begin
                    total++;
                    if (low_cnt != 2) begin
                        bad++;
                        $display("FAIL b2b_ready_low: %0d low samples, required 2", low_cnt);
                    end
                end
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
        total++;
        if (acc.size() != 5) begin
            bad++;
            $display("FAIL b2b_accept_count: got %0d, required 5", acc.size());
        end
        for (int k = 1; k < acc.size(); k++) begin
            total++;
            if (acc[k] - acc[k-1] != 3) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d edges, required 3", acc[k] - acc[k-1]);
            end
        end
        t = 0;
        while (q_b.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (q_b.size() != 0 || pops_b != acc.size()) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d pulses, required %0d", pops_b, acc.size());
            q_b.delete();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_word();
        test_subword_loads();
        test_store_lanes();
        test_errors();
        test_boundary();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
